// File: rtl/pixel_stream_source.sv
// Raster pixel source: streams one frame from image RAM, then zero flush pixels.
// Optional PIX_STREAM_PATTERN_EN adds test_mode, which emits (x+y) mod 256 without RAM reads.
module pixel_stream_source #(
  parameter int WIDTH     = 400,
  parameter int HEIGHT    = 300,
  parameter int ADDR_W    = 17,
  parameter int FLUSH_PIX = 1604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
`ifdef PIX_STREAM_PATTERN_EN
  input  logic              test_mode,
`endif
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [7:0]        dout,
  output logic              clk_en,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int FW = (FLUSH_PIX > 0) ? $clog2(FLUSH_PIX + 1) : 1;

  localparam logic [XW-1:0]     X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0]     Y_LAST = YW'(HEIGHT - 1);
  localparam logic [XW-1:0]     X_ONE  = XW'(1);
  localparam logic [YW-1:0]     Y_ONE  = YW'(1);
  localparam logic [ADDR_W-1:0] A_ONE  = ADDR_W'(1);
  localparam logic [FW-1:0]     F_LOAD = FW'(FLUSH_PIX);
  localparam logic [FW-1:0]     F_ONE  = FW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [ADDR_W-1:0] r_addr;
  logic [FW-1:0]     r_fcnt;
  logic              r_land;
  logic              r_vld;
  logic              r_ram;
  logic              r_sof;
  logic              r_eol;
  logic              r_eof;
  logic [7:0]        r_pix;

  logic              w_accept;
  logic              w_rd_issue;
  logic              w_fl_issue;
  logic              w_x_last;
  logic              w_last;
  logic              w_tm;
  logic [7:0]        w_xy;

`ifdef PIX_STREAM_PATTERN_EN
  logic r_tm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tm <= 1'b0;
    end else if (w_accept) begin
      r_tm <= test_mode;
    end
  end

  assign w_tm = r_tm;
`else
  assign w_tm = 1'b0;
`endif

  assign w_x_last = (r_x == X_LAST);
  assign w_last   = w_x_last && (r_y == Y_LAST);
  assign w_xy     = 8'(r_x) + 8'(r_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_rd_issue = 1'b0;
    w_fl_issue = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_READ;
        end
      end
      S_READ: begin
        if (!stall) begin
          w_rd_issue = 1'b1;
          if (w_last) begin
            w_next = (FLUSH_PIX == 0) ? S_FIN : S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (!stall) begin
          w_fl_issue = 1'b1;
          if (r_fcnt == F_ONE) begin
            w_next = S_FIN;
          end
        end
      end
      S_FIN: begin
        if (r_land) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_addr <= '0;
      r_fcnt <= '0;
      r_land <= 1'b0;
      r_vld  <= 1'b0;
      r_ram  <= 1'b0;
      r_sof  <= 1'b0;
      r_eol  <= 1'b0;
      r_eof  <= 1'b0;
      r_pix  <= '0;
    end else begin
      // Pixel and its markers land exactly one cycle after issue.
      r_vld  <= w_rd_issue | w_fl_issue;
      r_ram  <= w_rd_issue & ~w_tm;
      r_sof  <= w_rd_issue & (r_x == '0) & (r_y == '0);
      r_eol  <= w_rd_issue & w_x_last;
      r_eof  <= w_rd_issue & w_last;
      r_pix  <= (w_rd_issue & w_tm) ? w_xy : 8'd0;
      r_land <= (r_state == S_FIN) & ~r_land;
      if (w_accept) begin
        r_x    <= '0;
        r_y    <= '0;
        r_addr <= '0;
      end else if (w_rd_issue) begin
        r_addr <= r_addr + A_ONE;
        if (w_x_last) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + Y_ONE;
        end else begin
          r_x <= r_x + X_ONE;
        end
        if (w_last) begin
          r_fcnt <= F_LOAD;
        end
      end else if (w_fl_issue) begin
        r_fcnt <= r_fcnt - F_ONE;
      end
    end
  end

  assign mem_rd   = w_rd_issue & ~w_tm;
  assign mem_addr = r_addr;
  assign dout     = (r_vld && r_ram) ? mem_rdata : r_pix;
  assign clk_en   = r_vld;
  assign sof      = r_sof;
  assign eol      = r_eol;
  assign eof      = r_eof;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN) && r_land;

endmodule

// File: tb/tb_pixel_stream_source.sv
// Directed bench for pixel_stream_source: a 4x3 frame without flush
// (u_dut0) and with a 5-pixel flush (u_dut5), sharing stimulus.
module tb_pixel_stream_source;

  typedef struct {
    int         cyc;
    logic [7:0] d;
    logic [2:0] mk;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       test_mode = 1'b0;

  logic       mem_rd0, mem_rd5;
  logic [3:0] mem_addr0, mem_addr5;
  logic [7:0] rdata0 = 8'd0;
  logic [7:0] rdata5 = 8'd0;
  logic [7:0] dout0, dout5;
  logic       clk_en0, sof0, eol0, eof0, busy0, done0;
  logic       clk_en5, sof5, eol5, eof5, busy5, done5;

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  pix_t lg0[$];
  pix_t lg5[$];
  int   ad0[$];
  int   dn0 = 0;
  int   dn5 = 0;
  int   dc0 = 0;
  int   dc5 = 0;
  int   bad_mk = 0;

  always #5 clk = ~clk;

  pixel_stream_source #(
    .WIDTH(4), .HEIGHT(3), .ADDR_W(4), .FLUSH_PIX(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
`ifdef PIX_STREAM_PATTERN_EN
    .test_mode(test_mode),
`endif
    .mem_rd(mem_rd0), .mem_addr(mem_addr0), .mem_rdata(rdata0),
    .dout(dout0), .clk_en(clk_en0), .sof(sof0), .eol(eol0),
    .eof(eof0), .busy(busy0), .done(done0)
  );

  pixel_stream_source #(
    .WIDTH(4), .HEIGHT(3), .ADDR_W(4), .FLUSH_PIX(5)
  ) u_dut5 (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
`ifdef PIX_STREAM_PATTERN_EN
    .test_mode(test_mode),
`endif
    .mem_rd(mem_rd5), .mem_addr(mem_addr5), .mem_rdata(rdata5),
    .dout(dout5), .clk_en(clk_en5), .sof(sof5), .eol(eol5),
    .eof(eof5), .busy(busy5), .done(done5)
  );

  // RAM image: RAM[i] = i + 16, synchronous read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd0) rdata0 <= 8'(mem_addr0) + 8'd16;
    if (mem_rd5) rdata5 <= 8'(mem_addr5) + 8'd16;
  end

  always @(negedge clk) begin
    if (clk_en0) lg0.push_back('{cyc, dout0, {sof0, eol0, eof0}});
    if (clk_en5) lg5.push_back('{cyc, dout5, {sof5, eol5, eof5}});
    if (mem_rd0) ad0.push_back(int'(mem_addr0));
    if (done0) begin dn0++; dc0 = cyc; end
    if (done5) begin dn5++; dc5 = cyc; end
    if (!clk_en0 && {sof0, eol0, eof0} != 3'b0) bad_mk++;
    if (!clk_en5 && {sof5, eol5, eof5} != 3'b0) bad_mk++;
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(string tag);
    int k;
    for (k = 0; k < 100; k++) begin
      if (!busy0 && !busy5) break;
      step();
    end
    check({tag, "_idle_to"}, 32'(k < 100), 32'd1);
  endtask

  task automatic chk_frame(string tag, input pix_t q[$], input int b,
                           input int n_fl, input int stall_at,
                           input bit pat);
    int n;
    n = 12 + n_fl;
    check({tag, "_len"}, 32'(q.size() - b >= n), 32'd1);
    if (q.size() - b < n) return;
    for (int i = 0; i < n; i++) begin
      int         e;
      int         gap;
      logic [2:0] mk;
      gap = (stall_at >= 0 && i > stall_at) ? 3 : 0;
      if (i < 12) begin
        e  = pat ? (i % 4 + i / 4) : 16 + i;
        mk = {i == 0, i % 4 == 3, i == 11};
      end else begin
        e  = 0;
        mk = 3'b000;
      end
      check({tag, "_dout"}, 32'(q[b+i].d), 32'(e));
      check({tag, "_mk"}, 32'(q[b+i].mk), 32'(mk));
      check({tag, "_cyc"}, 32'(q[b+i].cyc - q[b].cyc), 32'(i + gap));
    end
  endtask

  task automatic chk_addr(string tag, input int b);
    check({tag, "_nrd"}, 32'(ad0.size() - b), 32'd12);
    for (int i = 0; i < 12 && b + i < ad0.size(); i++)
      check({tag, "_addr"}, 32'(ad0[b+i]), 32'(i));
  endtask

  function automatic logic [31:0] outs0();
    return {14'd0, mem_rd0, mem_addr0, dout0, clk_en0, sof0,
            eol0, eof0, busy0, done0};
  endfunction

  function automatic logic [31:0] outs5();
    return {14'd0, mem_rd5, mem_addr5, dout5, clk_en5, sof5,
            eol5, eof5, busy5, done5};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, b5, ab, bd, bd5, k, dfirst;
    bit found;

    repeat (3) step();
    check("rst_outs0", outs0(), 32'd0);
    check("rst_outs5", outs5(), 32'd0);
    rst_n = 1'b1;
    step();

    // basic frame, with and without flush
    b0 = lg0.size(); b5 = lg5.size(); ab = ad0.size();
    bd = dn0; bd5 = dn5;
    pulse_start();
    wait_idle("basic");
    check("basic_n0", 32'(lg0.size() - b0), 32'd12);
    check("basic_n5", 32'(lg5.size() - b5), 32'd17);
    chk_frame("basic0", lg0, b0, 0, -1, 1'b0);
    chk_frame("basic5", lg5, b5, 5, -1, 1'b0);
    chk_addr("basic", ab);
    check("basic_dn0", 32'(dn0 - bd), 32'd1);
    check("basic_dn5", 32'(dn5 - bd5), 32'd1);
    if (lg0.size() > 0)
      check("basic_dcyc0", 32'(dc0 - lg0[lg0.size()-1].cyc), 32'd1);
    if (lg5.size() > 0)
      check("basic_dcyc5", 32'(dc5 - lg5[lg5.size()-1].cyc), 32'd1);

    // stall for 3 cycles after address 5 issues
    b0 = lg0.size(); b5 = lg5.size(); ab = ad0.size();
    pulse_start();
    found = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (mem_rd0 && mem_addr0 == 4'd5) begin found = 1'b1; break; end
      step();
    end
    check("stall_a5_seen", 32'(found), 32'd1);
    step();
    stall = 1'b1;
    check("stall_pix21", {23'd0, clk_en0, dout0}, {23'd0, 1'b1, 8'd21});
    step();
    check("stall_nord", {31'd0, mem_rd0}, 32'd0);
    repeat (2) step();
    stall = 1'b0;
    wait_idle("stall");
    check("stall_n0", 32'(lg0.size() - b0), 32'd12);
    check("stall_n5", 32'(lg5.size() - b5), 32'd17);
    chk_frame("stall0", lg0, b0, 0, 5, 1'b0);
    chk_addr("stall", ab);

    // start while busy is ignored; start right after done is accepted
    b0 = lg0.size(); ab = ad0.size(); bd = dn0;
    pulse_start();
    found = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (clk_en0 && dout0 == 8'd23) begin found = 1'b1; break; end
      step();
    end
    check("sb_pix23_seen", 32'(found), 32'd1);
    pulse_start();
    for (k = 0; k < 40; k++) begin
      if (done0) break;
      step();
    end
    check("sb_done_to", 32'(k < 40), 32'd1);
    check("sb_busy_at_done", {31'd0, busy0}, 32'd1);
    dfirst = cyc;
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    wait_idle("sb");
    check("sb_n0", 32'(lg0.size() - b0), 32'd24);
    check("sb_dn", 32'(dn0 - bd), 32'd2);
    chk_frame("sb_f1", lg0, b0, 0, -1, 1'b0);
    chk_frame("sb_f2", lg0, b0 + 12, 0, -1, 1'b0);
    if (lg0.size() >= b0 + 13)
      check("sb_f2_start", 32'(lg0[b0+12].cyc - dfirst), 32'd3);
    check("sb_nrd", 32'(ad0.size() - ab), 32'd24);

    // reset in the middle of a frame
    bd = dn0; bd5 = dn5;
    pulse_start();
    found = 1'b0;
    for (k = 0; k < 20; k++) begin
      if (clk_en0 && dout0 == 8'd22) begin found = 1'b1; break; end
      step();
    end
    check("rm_pix22_seen", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rm_outs0", outs0(), 32'd0);
    check("rm_outs5", outs5(), 32'd0);
    repeat (4) step();
    check("rm_nodone", 32'((dn0 - bd) + (dn5 - bd5)), 32'd0);
    rst_n = 1'b1;
    step();
    b0 = lg0.size(); b5 = lg5.size(); ab = ad0.size();
    pulse_start();
    wait_idle("rm");
    check("rm_n0", 32'(lg0.size() - b0), 32'd12);
    check("rm_n5", 32'(lg5.size() - b5), 32'd17);
    chk_frame("rm0", lg0, b0, 0, -1, 1'b0);
    chk_frame("rm5", lg5, b5, 5, -1, 1'b0);
    chk_addr("rm", ab);

`ifdef PIX_STREAM_PATTERN_EN
    // pattern mode: no RAM reads, dout = x + y
    b0 = lg0.size(); b5 = lg5.size(); ab = ad0.size();
    test_mode = 1'b1;
    pulse_start();
    test_mode = 1'b0;
    wait_idle("pat");
    check("pat_nrd", 32'(ad0.size() - ab), 32'd0);
    check("pat_n0", 32'(lg0.size() - b0), 32'd12);
    chk_frame("pat0", lg0, b0, 0, -1, 1'b1);
    chk_frame("pat5", lg5, b5, 5, -1, 1'b1);
`endif

    check("markers_only_valid", 32'(bad_mk), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_stream_source.md
Name: pixel_stream_source

Overview:
- Raster pixel producer: reads one 8-bit greyscale frame from a synchronous-read image RAM and drives the pixel/clk_en stream that the separable Gaussian stages and their 400-deep line shift RAMs consume.
- After the last image pixel it emits FLUSH_PIX zero pixels. This drains the vertical filter's line-buffer pipeline so the final rows reach downstream.
- Sits between the frame buffer and the first blur stage of the octave pipeline.

Parameters:
- WIDTH, 400, pixels per row; must match the downstream line-buffer depth.
- HEIGHT, 300, rows per frame.
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- FLUSH_PIX, 1604, zero pixels appended after the frame (4 rows + 4 taps); 0 disables flushing.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to stream a frame; ignored unless idle.
- stall  in  1  downstream back-pressure; while high, no new RAM reads are issued.
- mem_rd  out  1  RAM read strobe.
- mem_addr  out  ADDR_W  RAM read address, linear y*WIDTH+x.
- mem_rdata  in  8  RAM read data, valid exactly one cycle after mem_rd.
- dout  out  8  pixel value.
- clk_en  out  1  pixel-valid strobe; drives downstream clk_en.
- sof  out  1  high with the first image pixel.
- eol  out  1  high with the last pixel of each image row.
- eof  out  1  high with the last image pixel.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final clk_en (image or flush).

Behaviour:
- Reset (async, rst_n=0): state IDLE; x, y, mem_addr, flush counter = 0; mem_rd, clk_en, sof, eol, eof, busy, done = 0; dout = 0. Reset mid-frame aborts the frame silently, with no done pulse.
- States: IDLE, READ, FLUSH, FIN.
- IDLE: if start, go to READ, set busy=1, clear x/y/addr. Start while busy is ignored.
- READ: each cycle with stall=0, assert mem_rd with mem_addr = current address, then advance the counters. x wraps at WIDTH-1 to 0 and increments y. The address increments by 1 with no multiplier.
- READ exit: when the read for (WIDTH-1, HEIGHT-1) issues, go to FLUSH, or to FIN if FLUSH_PIX=0.
- Stall: while stall=1, mem_rd=0 and the counters hold.
- Output timing: fixed 1-cycle latency. If mem_rd=1 at cycle t, then clk_en=1 and dout=mem_rdata at t+1, regardless of stall at t+1. Downstream must accept one in-flight pixel after raising stall.
- Frame markers: sof, eol and eof are registered alongside the pixel they tag and are only high while clk_en=1.
- FLUSH: on each cycle with stall=0, output clk_en=1, dout=0, and decrement the flush count. After FLUSH_PIX pixels go to FIN. Flush pixels never assert sof, eol or eof, and never read RAM.
- FIN: wait one cycle so the last in-flight pixel lands, then pulse done=1 for one cycle, clear busy, and return to IDLE.
- Simultaneous events: done and a new start in the same cycle means start is ignored (busy is still high). A start in the cycle after done is accepted.
- Widths: the x counter is sized for WIDTH-1, y for HEIGHT-1, and the flush counter for FLUSH_PIX.

Optional Feature:
- Macro: PIX_STREAM_PATTERN_EN.
- Defined: adds input port test_mode (1 bit, sampled at start acceptance).
  - If test_mode is latched high, mem_rd stays 0 for the whole frame.
  - dout = (x + y) mod 256 of the pixel being emitted, with identical 1-cycle timing, clk_en, stall, markers and flush behaviour.
- Not defined: the port is absent and all pixels come from RAM.

Test Plan:
- Basic frame (WIDTH=4, HEIGHT=3, FLUSH_PIX=0; RAM[i]=i+16): pulse start -> 12 clk_en pixels 16..27 in order, consecutive cycles, addr 0..11. sof on pixel 16; eol on 19, 23, 27; eof on 27; done one cycle after pixel 27.
- Flush (same frame, FLUSH_PIX=5) -> after pixel 27, exactly 5 clk_en cycles with dout=0 and no markers, then done; 17 clk_en total.
- Stall: raise stall for 3 cycles right after addr 5 is issued -> pixel 21 still appears next cycle, then no clk_en for 3 cycles, resume at 22. No pixel is lost or duplicated.
- Start while busy: pulse start at pixel 7 -> ignored, frame completes normally, one done. A start on the cycle after done launches a second identical frame.
- Reset mid-frame: rst_n low at pixel 6 -> all outputs 0 immediately, no done. After release and start, a full frame streams from addr 0.
- PIX_STREAM_PATTERN_EN with test_mode=1 (4x3) -> mem_rd never high. dout sequence 0,1,2,3, 1,2,3,4, 2,3,4,5.
